ps2_matrix_mapper: RTL and testbench

- Parametrised successor to the fixed PS/2-to-matrix keyboard block.
- Converts PS/2 scancode bytes into a ROWS x COLS active-low key matrix that the host chip scans.
- Uses a run-time-loadable map RAM, so one block serves any keyboard layout or machine variant.
- Adds three features:
  - Pause-sequence reset pulse with a programmable width.
  - Release-all on request or on keyboard BAT.
  - Overrun detection.
- Sits between the ps2_intf byte decoder and the VTL/IO address decode.

---
 rtl/ps2_map_pkg.sv | 28 ++
 rtl/ps2_matrix_mapper_if.sv | 21 ++
 rtl/ps2_map_ram.sv | 24 ++
 rtl/ps2_matrix_mapper.sv | 137 +++++++++++++
 tb/tb_ps2_matrix_mapper.sv | 392 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_map_pkg.sv
// Shared types for the PS/2 to key-matrix mapper.
// Scancode constants, map entry layout and decoder state encoding.
package ps2_map_pkg;

  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BRK   = 8'hF0;
  localparam logic [7:0] PS2_PAUSE = 8'hE1;
  localparam logic [7:0] PS2_BAT   = 8'hAA;

  localparam int IDX_W     = 9;
  localparam int ENT_W     = 9;
  localparam int PAUSE_LEN = 7;

  typedef struct packed {
    logic       valid;
    logic       auto_shift;
    logic [3:0] row;
    logic [2:0] col;
  } map_entry_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOOKUP,
    S_APPLY,
    S_PAUSE
  } state_t;

endpackage

// File: rtl/ps2_matrix_mapper_if.sv
// Byte stream from the PS/2 decoder plus the map RAM write port.
// master: byte/map source; slave: the mapper.
interface ps2_matrix_mapper_if;
  import ps2_map_pkg::*;

  logic [7:0]       ps2_byte;
  logic             ps2_valid;
  logic             map_we;
  logic [IDX_W-1:0] map_addr;
  map_entry_t       map_wdata;

  modport master (
    output ps2_byte, ps2_valid,
    output map_we, map_addr, map_wdata
  );

  modport slave (
    input ps2_byte, ps2_valid,
    input map_we, map_addr, map_wdata
  );
endinterface

// File: rtl/ps2_map_ram.sv
// 512x9 simple dual-port map RAM, registered read, old data on collision.
// Ports: clk, we/waddr/wdata write side, raddr/rdata read side.
module ps2_map_ram
  import ps2_map_pkg::*;
#(
  parameter MAP_INIT = ""
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  map_entry_t       wdata,
  input  logic [IDX_W-1:0] raddr,
  output map_entry_t       rdata
);

  logic [ENT_W-1:0] mem [1<<IDX_W];

  always_ff @(posedge clk) begin
    if (we)
      mem[waddr] <= wdata;
    rdata <= map_entry_t'(mem[raddr]);
  end

endmodule

// File: rtl/ps2_matrix_mapper.sv
// PS/2 scancode to active-low ROWS x COLS key matrix with loadable map.
// Ports: clk, reset, bus (bytes + map writes), row_sel_n/kd, release_all, reset_key, overrun.
module ps2_matrix_mapper
  import ps2_map_pkg::*;
#(
  parameter int ROWS      = 12,
  parameter int COLS      = 7,
  parameter int SHIFT_ROW = 0,
  parameter int SHIFT_COL = 6,
  parameter int RST_PULSE = 16,
  parameter     MAP_INIT  = ""
) (
  input  logic                 clk,
  input  logic                 reset,
  ps2_matrix_mapper_if.slave   bus,
  input  logic [ROWS-1:0]      row_sel_n,
  output logic [COLS-1:0]      kd,
  input  logic                 release_all,
  output logic                 reset_key,
  output logic                 overrun
);

  localparam int PW = (RST_PULSE > 1) ? $clog2(RST_PULSE) : 1;

  state_t                     state;
  logic                       ext;
  logic                       brk;
  logic [IDX_W-1:0]           idx;
  logic [2:0]                 pcnt;
  logic [PW-1:0]              pulse_cnt;
  logic [ROWS-1:0][COLS-1:0]  mat;
  map_entry_t                 ent;
  logic                       busy;

  ps2_map_ram #(
    .MAP_INIT (MAP_INIT)
  ) u_ram (
    .clk   (clk),
    .we    (bus.map_we),
    .waddr (bus.map_addr),
    .wdata (bus.map_wdata),
    .raddr (idx),
    .rdata (ent)
  );

  assign busy = (state == S_LOOKUP) || (state == S_APPLY);

  always_comb begin
    kd = '1;
    for (int r = 0; r < ROWS; r++)
      if (!row_sel_n[r])
        kd = kd & mat[r];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      ext       <= 1'b0;
      brk       <= 1'b0;
      idx       <= '0;
      pcnt      <= '0;
      pulse_cnt <= '0;
      reset_key <= 1'b0;
      overrun   <= 1'b0;
      mat       <= '1;
    end else begin
      overrun <= busy && bus.ps2_valid;

      if (reset_key) begin
        if (pulse_cnt == '0)
          reset_key <= 1'b0;
        else
          pulse_cnt <= pulse_cnt - 1'b1;
      end

      unique case (state)
        S_IDLE: begin
          if (bus.ps2_valid && !release_all) begin
            unique case (1'b1)
              (bus.ps2_byte == PS2_EXT): ext <= 1'b1;
              (bus.ps2_byte == PS2_BRK): brk <= 1'b1;
              (bus.ps2_byte == PS2_PAUSE): begin
                pcnt      <= 3'(PAUSE_LEN);
                state     <= S_PAUSE;
                reset_key <= 1'b1;
                pulse_cnt <= PW'(RST_PULSE - 1);
              end
              (bus.ps2_byte == PS2_BAT): begin
                mat <= '1;
                ext <= 1'b0;
                brk <= 1'b0;
              end
              default: begin
                idx   <= {ext, bus.ps2_byte};
                state <= S_LOOKUP;
              end
            endcase
          end
        end
        S_LOOKUP: state <= S_APPLY;
        S_APPLY: begin
          if (ent.valid && int'(ent.row) < ROWS &&
              int'(ent.col) < COLS) begin
            for (int r = 0; r < ROWS; r++)
              for (int c = 0; c < COLS; c++)
                if (r == int'(ent.row) && c == int'(ent.col))
                  mat[r][c] <= brk;
            if (ent.auto_shift)
              mat[SHIFT_ROW][SHIFT_COL] <= brk;
          end
          ext   <= 1'b0;
          brk   <= 1'b0;
          state <= S_IDLE;
        end
        S_PAUSE: begin
          // Swallow the tail of the Pause sequence, E1 included.
          if (bus.ps2_valid) begin
            pcnt <= pcnt - 1'b1;
            if (pcnt == 3'd1)
              state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase

      // Wins over any matrix write above; drops a pending lookup.
      if (release_all) begin
        mat <= '1;
        ext <= 1'b0;
        brk <= 1'b0;
        if (busy)
          state <= S_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_ps2_matrix_mapper.sv
// Self-checking bench for ps2_matrix_mapper.
// Expected kd rows are queued as keys are sent, then popped and compared.
module tb_ps2_matrix_mapper;
  import ps2_map_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] row_sel_n = '1;
  logic [6:0]  kd;
  logic        release_all = 1'b0;
  logic        reset_key;
  logic        overrun;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    int         row;
    logic [6:0] kd;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;

  ps2_matrix_mapper_if bus();

  ps2_matrix_mapper u_dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .row_sel_n   (row_sel_n),
    .kd          (kd),
    .release_all (release_all),
    .reset_key   (reset_key),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    bus.ps2_valid = 1'b1;
    bus.ps2_byte  = b;
    @(negedge clk);
    bus.ps2_valid = 1'b0;
  endtask

  task automatic key(input logic [7:0] b);
    send(b);
    repeat (3) @(negedge clk);
  endtask

  task automatic load(input logic [8:0] a, input logic [8:0] d);
    @(negedge clk);
    bus.map_we    = 1'b1;
    bus.map_addr  = a;
    bus.map_wdata = d;
    @(negedge clk);
    bus.map_we    = 1'b0;
  endtask

  task automatic pulse_release();
    @(negedge clk);
    release_all = 1'b1;
    @(negedge clk);
    release_all = 1'b0;
  endtask

  task automatic test_reset();
    bus.ps2_valid = 1'b0;
    bus.ps2_byte  = '0;
    bus.map_we    = 1'b0;
    bus.map_addr  = '0;
    bus.map_wdata = '0;
    reset = 1'b1;
    // map writes land even while reset is held
    load(9'h01C, {1'b1, 1'b0, 4'd1,  3'd5});
    load(9'h11C, {1'b1, 1'b0, 4'd2,  3'd0});
    load(9'h175, {1'b1, 1'b0, 4'd10, 3'd3});
    load(9'h079, {1'b1, 1'b1, 4'd4,  3'd5});
    load(9'h01A, {1'b1, 1'b0, 4'd3,  3'd2});
    load(9'h075, {1'b1, 1'b0, 4'd9,  3'd1});
    @(negedge clk);
    reset = 1'b0;
    row_sel_n = '0;
    #1;
    checks++;
    if (kd !== 7'h7F) begin
      errors++;
      $display("FAIL reset_kd got=%h exp=7f", kd);
    end
    checks++;
    if (reset_key !== 1'b0) begin
      errors++;
      $display("FAIL reset_key got=%b exp=0", reset_key);
    end
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_overrun got=%b exp=0", overrun);
    end
    row_sel_n = '1;
    #1;
    checks++;
    if (kd !== 7'h7F) begin
      errors++;
      $display("FAIL no_row_sel got=%h exp=7f", kd);
    end
  endtask

  task automatic test_press_latency();
    row_sel_n = ~(12'd1 << 1);
    send(8'h1C);
    @(negedge clk);
    checks++;
    if (kd !== 7'h7F) begin
      errors++;
      $display("FAIL latency_n1 got=%h exp=7f", kd);
    end
    @(negedge clk);
    checks++;
    if (kd !== 7'h5F) begin
      errors++;
      $display("FAIL latency_n2 got=%h exp=5f", kd);
    end
    exp_q.push_back('{"press_row0", 0, 7'h7F});
    exp_q.push_back('{"press_rows01", -1, 7'h5F});
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      row_sel_n = (e.row < 0) ? ~12'b11 : ~(12'd1 << e.row);
      #1;
      checks++;
      if (kd !== e.kd) begin
        errors++;
        $display("FAIL %s got=%h exp=%h", e.name, kd, e.kd);
      end
    end
    send(PS2_BRK);
    key(8'h1C);
    exp_q.push_back('{"break_1c", 1, 7'h7F});
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      row_sel_n = ~(12'd1 << e.row);
      #1;
      checks++;
      if (kd !== e.kd) begin
        errors++;
        $display("FAIL %s got=%h exp=%h", e.name, kd, e.kd);
      end
    end
  endtask

  task automatic test_extended();
    send(PS2_EXT);
    key(8'h75);
    exp_q.push_back('{"ext_row10", 10, 7'h77});
    key(8'h1C);
    exp_q.push_back('{"plain_1c_row1", 1, 7'h5F});
    exp_q.push_back('{"not_11c_row2", 2, 7'h7F});
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      row_sel_n = ~(12'd1 << e.row);
      #1;
      checks++;
      if (kd !== e.kd) begin
        errors++;
        $display("FAIL %s got=%h exp=%h", e.name, kd, e.kd);
      end
    end
    send(PS2_EXT);
    send(PS2_BRK);
    key(8'h75);
    send(PS2_BRK);
    key(8'h1C);
    exp_q.push_back('{"ext_break_row10", 10, 7'h7F});
    exp_q.push_back('{"break_row1", 1, 7'h7F});
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      row_sel_n = ~(12'd1 << e.row);
      #1;
      checks++;
      if (kd !== e.kd) begin
        errors++;
        $display("FAIL %s got=%h exp=%h", e.name, kd, e.kd);
      end
    end
  endtask

  task automatic test_auto_shift();
    key(8'h79);
    exp_q.push_back('{"shift_key_row4", 4, 7'h5F});
    exp_q.push_back('{"shift_row0", 0, 7'h3F});
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      row_sel_n = ~(12'd1 << e.row);
      #1;
      checks++;
      if (kd !== e.kd) begin
        errors++;
        $display("FAIL %s got=%h exp=%h", e.name, kd, e.kd);
      end
    end
    send(PS2_BRK);
    key(8'h79);
    exp_q.push_back('{"unshift_row4", 4, 7'h7F});
    exp_q.push_back('{"unshift_row0", 0, 7'h7F});
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      row_sel_n = ~(12'd1 << e.row);
      #1;
      checks++;
      if (kd !== e.kd) begin
        errors++;
        $display("FAIL %s got=%h exp=%h", e.name, kd, e.kd);
      end
    end
  endtask

  task automatic test_pause();
    logic [7:0] seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1,
                            8'hF0, 8'h14, 8'hF0, 8'h77};
    int hi = 0;
    int ov = 0;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          @(negedge clk);
          bus.ps2_valid = 1'b1;
          bus.ps2_byte  = seq[i];
        end
        @(negedge clk);
        bus.ps2_valid = 1'b0;
      end
      begin
        repeat (60) begin
          @(negedge clk);
          if (reset_key) hi++;
          if (overrun) ov++;
        end
      end
    join
    checks++;
    if (hi !== 16) begin
      errors++;
      $display("FAIL pause_pulse_width got=%0d exp=16", hi);
    end
    checks++;
    if (ov !== 0) begin
      errors++;
      $display("FAIL pause_overrun got=%0d exp=0", ov);
    end
    row_sel_n = '0;
    #1;
    checks++;
    if (kd !== 7'h7F) begin
      errors++;
      $display("FAIL pause_matrix got=%h exp=7f", kd);
    end
    key(8'h1C);
    exp_q.push_back('{"after_pause_1c", 1, 7'h5F});
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      row_sel_n = ~(12'd1 << e.row);
      #1;
      checks++;
      if (kd !== e.kd) begin
        errors++;
        $display("FAIL %s got=%h exp=%h", e.name, kd, e.kd);
      end
    end
    send(PS2_BRK);
    key(8'h1C);
  endtask

  task automatic test_release_all();
    key(8'h1C);
    key(8'h1A);
    exp_q.push_back('{"held_a_row1", 1, 7'h5F});
    exp_q.push_back('{"held_z_row3", 3, 7'h7B});
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      row_sel_n = ~(12'd1 << e.row);
      #1;
      checks++;
      if (kd !== e.kd) begin
        errors++;
        $display("FAIL %s got=%h exp=%h", e.name, kd, e.kd);
      end
    end
    pulse_release();
    row_sel_n = '0;
    #1;
    checks++;
    if (kd !== 7'h7F) begin
      errors++;
      $display("FAIL release_all got=%h exp=7f", kd);
    end
    key(8'h1C);
    key(8'h1A);
    key(PS2_BAT);
    row_sel_n = '0;
    #1;
    checks++;
    if (kd !== 7'h7F) begin
      errors++;
      $display("FAIL bat_release got=%h exp=7f", kd);
    end
  endtask

  task automatic test_overrun();
    int ov = 0;
    fork
      begin
        @(negedge clk);
        bus.ps2_valid = 1'b1;
        bus.ps2_byte  = 8'h1C;
        @(negedge clk);
        bus.ps2_byte  = 8'h1A;
        @(negedge clk);
        bus.ps2_valid = 1'b0;
      end
      begin
        repeat (8) begin
          @(negedge clk);
          if (overrun) ov++;
        end
      end
    join
    checks++;
    if (ov !== 1) begin
      errors++;
      $display("FAIL overrun_pulses got=%0d exp=1", ov);
    end
    exp_q.push_back('{"overrun_kept_row1", 1, 7'h5F});
    exp_q.push_back('{"overrun_dropped_row3", 3, 7'h7F});
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      row_sel_n = ~(12'd1 << e.row);
      #1;
      checks++;
      if (kd !== e.kd) begin
        errors++;
        $display("FAIL %s got=%h exp=%h", e.name, kd, e.kd);
      end
    end
    pulse_release();
  endtask

  task automatic test_back_to_back();
    // release_all while the lookup is pending discards it
    send(8'h1C);
    release_all = 1'b1;
    @(negedge clk);
    release_all = 1'b0;
    repeat (3) @(negedge clk);
    exp_q.push_back('{"release_discards_apply", 1, 7'h7F});
    // reset after E0 forgets the prefix
    send(PS2_EXT);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    key(8'h75);
    exp_q.push_back('{"reset_drops_ext_row9", 9, 7'h7D});
    exp_q.push_back('{"reset_drops_ext_row10", 10, 7'h7F});
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      row_sel_n = ~(12'd1 << e.row);
      #1;
      checks++;
      if (kd !== e.kd) begin
        errors++;
        $display("FAIL %s got=%h exp=%h", e.name, kd, e.kd);
      end
    end
  endtask

  initial begin
    test_reset();
    test_press_latency();
    test_extended();
    test_auto_shift();
    test_pause();
    test_release_all();
    test_overrun();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
